// File: rtl/shift_execute_stage.sv
`timescale 1ns/1ps
// Two-stage pipelined MIPS shift execute unit (SLL/SRL/SRA/SLLV/SRLV/SRAV).
// S1 captures the decoded op; S2 captures the shift result and drives the outputs.
module shift_execute_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int SHAMT_WIDTH    = 5,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [5:0]                funct,
  input  logic [SHAMT_WIDTH-1:0]    shamt,
  input  logic [DATA_WIDTH-1:0]     rs_val,
  input  logic [DATA_WIDTH-1:0]     rt_val,
  input  logic [REG_ADDR_WIDTH-1:0] dest,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_WIDTH-1:0]     out_result,
  output logic [REG_ADDR_WIDTH-1:0] out_dest,
  output logic                      out_illegal
);

  typedef enum logic [1:0] {
    KIND_LL = 2'd0,
    KIND_LR = 2'd1,
    KIND_AR = 2'd2
  } kind_t;

  // S1 registers
  logic                      s1_valid_reg;
  kind_t                     s1_kind_reg;
  logic [SHAMT_WIDTH-1:0]    s1_amt_reg;
  logic [DATA_WIDTH-1:0]     s1_rt_reg;
  logic [REG_ADDR_WIDTH-1:0] s1_dest_reg;
  logic                      s1_illegal_reg;

  // S2 registers
  logic                      s2_valid_reg;
  logic [DATA_WIDTH-1:0]     s2_result_reg;
  logic [REG_ADDR_WIDTH-1:0] s2_dest_reg;
  logic                      s2_illegal_reg;

  // Decode results
  kind_t                     kind_next;
  logic [SHAMT_WIDTH-1:0]    amt_next;
  logic                      illegal_next;
  logic [DATA_WIDTH-1:0]     result_next;

  logic s2_adv;
  logic s1_adv;
  logic s1_load;
  logic s2_load;

  // Only the low bits of rs carry a shift amount; the rest is deliberately ignored.
  logic rs_upper_unused;
  assign rs_upper_unused = ^rs_val[DATA_WIDTH-1:SHAMT_WIDTH];

  assign s2_adv   = !s2_valid_reg || out_ready;
  assign s1_adv   = !s1_valid_reg || s2_adv;
  assign in_ready = s1_adv;
  assign s1_load  = in_valid && s1_adv;
  assign s2_load  = s1_valid_reg && s2_adv;

  // Decode funct into shift kind, amount source and illegal flag.
  always_comb begin
    kind_next    = KIND_LL;
    amt_next     = shamt;
    illegal_next = 1'b0;
    case (funct)
      6'b000000: kind_next = KIND_LL;
      6'b000010: kind_next = KIND_LR;
      6'b000011: kind_next = KIND_AR;
      6'b000100: begin kind_next = KIND_LL; amt_next = rs_val[SHAMT_WIDTH-1:0]; end
      6'b000110: begin kind_next = KIND_LR; amt_next = rs_val[SHAMT_WIDTH-1:0]; end
      6'b000111: begin kind_next = KIND_AR; amt_next = rs_val[SHAMT_WIDTH-1:0]; end
      default:   illegal_next = 1'b1;
    endcase
  end

  // Log-depth barrel shifters: stage gi shifts by 2**gi when amount bit gi is set.
  genvar gi;
  generate
    for (gi = 0; gi < SHAMT_WIDTH; gi++) begin : g_stage
      localparam int SH = 1 << gi;
      logic [DATA_WIDTH-1:0] ll_in, lr_in, ar_in;
      logic [DATA_WIDTH-1:0] ll_out, lr_out, ar_out;
      if (gi == 0) begin : g_first
        assign ll_in = s1_rt_reg;
        assign lr_in = s1_rt_reg;
        assign ar_in = s1_rt_reg;
      end else begin : g_chain
        assign ll_in = g_stage[gi-1].ll_out;
        assign lr_in = g_stage[gi-1].lr_out;
        assign ar_in = g_stage[gi-1].ar_out;
      end
      assign ll_out = s1_amt_reg[gi] ? {ll_in[DATA_WIDTH-SH-1:0], {SH{1'b0}}} : ll_in;
      assign lr_out = s1_amt_reg[gi] ? {{SH{1'b0}}, lr_in[DATA_WIDTH-1:SH]} : lr_in;
      assign ar_out = s1_amt_reg[gi] ? {{SH{s1_rt_reg[DATA_WIDTH-1]}}, ar_in[DATA_WIDTH-1:SH]} : ar_in;
    end
  endgenerate

  // Select the shifter matching the S1 op kind; illegal ops produce zero.
  always_comb begin
    result_next = '0;
    if (!s1_illegal_reg) begin
      case (s1_kind_reg)
        KIND_LL: result_next = g_stage[SHAMT_WIDTH-1].ll_out;
        KIND_LR: result_next = g_stage[SHAMT_WIDTH-1].lr_out;
        KIND_AR: result_next = g_stage[SHAMT_WIDTH-1].ar_out;
        default: result_next = '0;
      endcase
    end
  end

  // S1: capture decoded op on input handshake; flush squashes the valid bit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_valid_reg   <= 1'b0;
      s1_kind_reg    <= KIND_LL;
      s1_amt_reg     <= '0;
      s1_rt_reg      <= '0;
      s1_dest_reg    <= '0;
      s1_illegal_reg <= 1'b0;
    end else begin
      if (flush)
        s1_valid_reg <= 1'b0;
      else if (s1_adv)
        s1_valid_reg <= in_valid;
      if (s1_load) begin
        s1_kind_reg    <= kind_next;
        s1_amt_reg     <= amt_next;
        s1_rt_reg      <= rt_val;
        s1_dest_reg    <= dest;
        s1_illegal_reg <= illegal_next;
      end
    end
  end

  // S2: capture shift result when S1 advances; holds while downstream stalls.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s2_valid_reg   <= 1'b0;
      s2_result_reg  <= '0;
      s2_dest_reg    <= '0;
      s2_illegal_reg <= 1'b0;
    end else begin
      if (flush)
        s2_valid_reg <= 1'b0;
      else if (s2_adv)
        s2_valid_reg <= s1_valid_reg;
      if (s2_load) begin
        s2_result_reg  <= result_next;
        s2_dest_reg    <= s1_dest_reg;
        s2_illegal_reg <= s1_illegal_reg;
      end
    end
  end

  assign out_valid   = s2_valid_reg;
  assign out_result  = s2_result_reg;
  assign out_dest    = s2_dest_reg;
  assign out_illegal = s2_illegal_reg;

endmodule

// File: tb/tb_shift_execute_stage.sv
`timescale 1ns/1ps
// Self-checking bench for shift_execute_stage: directed cases plus randomized traffic
// compared every cycle against a queue-based behavioural model.
module tb_shift_execute_stage;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [5:0]  funct = '0;
  logic [4:0]  shamt = '0;
  logic [31:0] rs_val = '0;
  logic [31:0] rt_val = '0;
  logic [4:0]  dest = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic [4:0]  out_dest;
  logic        out_illegal;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  dest;
    logic        ill;
    int          age;
  } exp_t;
  exp_t q[$];

  logic last_in_ready;

  localparam logic [5:0] F_SLL = 6'b000000, F_SRL = 6'b000010, F_SRA = 6'b000011;
  localparam logic [5:0] F_SLLV = 6'b000100, F_SRLV = 6'b000110, F_SRAV = 6'b000111;
  localparam logic [5:0] F_ADD = 6'b100000;

  shift_execute_stage dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .funct(funct), .shamt(shamt), .rs_val(rs_val), .rt_val(rt_val), .dest(dest),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_dest(out_dest), .out_illegal(out_illegal)
  );

  always #5 clock = ~clock;

  // Reference: MIPS shift semantics in plain arithmetic.
  function automatic void ref_op(input logic [5:0] f, input logic [4:0] sh,
                                 input logic [31:0] rs, input logic [31:0] rt,
                                 output logic [31:0] res, output logic ill);
    int amt;
    amt = f[2] ? int'(rs % 32) : int'(sh);
    ill = 1'b0;
    case (f)
      F_SLL, F_SLLV: res = rt << amt;
      F_SRL, F_SRLV: res = rt >> amt;
      F_SRA, F_SRAV: res = rt[31] ? ~((~rt) >> amt) : (rt >> amt);
      default: begin res = 32'h0; ill = 1'b1; end
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
    end
  endtask

  // Compare DUT outputs against the model's view of the pipeline.
  task automatic compare();
    bit ev;
    bit er;
    ev = (q.size() > 0) && (q[0].age >= 1);
    er = (q.size() < 2) || out_ready;
    chk("out_valid", 32'(out_valid), 32'(ev));
    chk("in_ready", 32'(in_ready), 32'(er));
    if (ev) begin
      chk("out_result", out_result, q[0].res);
      chk("out_dest", 32'(out_dest), 32'(q[0].dest));
      chk("out_illegal", 32'(out_illegal), 32'(q[0].ill));
    end
  endtask

  // One clock cycle: drive at negedge, check, then advance the model at posedge.
  task automatic cycle(input bit iv, input logic [5:0] f, input logic [4:0] sh,
                       input logic [31:0] rs, input logic [31:0] rt, input logic [4:0] d,
                       input bit ordy, input bit fl, output bit accepted);
    bit cons;
    exp_t e;
    @(negedge clock);
    in_valid = iv; funct = f; shamt = sh; rs_val = rs; rt_val = rt; dest = d;
    out_ready = ordy; flush = fl;
    #1;
    compare();
    last_in_ready = in_ready;
    accepted = iv && ((q.size() < 2) || ordy);
    cons = (q.size() > 0) && (q[0].age >= 1) && ordy;
    @(posedge clock);
    foreach (q[i]) begin e = q[i]; e.age++; q[i] = e; end
    if (cons) void'(q.pop_front());
    if (fl) q.delete();
    else if (accepted) begin
      ref_op(f, sh, rs, rt, e.res, e.ill);
      e.dest = d; e.age = 0;
      q.push_back(e);
    end
    #1;
  endtask

  task automatic idle(input bit ordy);
    bit a;
    cycle(1'b0, 6'h0, 5'h0, 32'h0, 32'h0, 5'h0, ordy, 1'b0, a);
  endtask

  initial begin
    bit a;
    logic [31:0] r;
    logic il;
    logic [5:0] legal [6];
    int guard;
    legal = '{F_SLL, F_SRL, F_SRA, F_SLLV, F_SRLV, F_SRAV};

    // Model pinning with hand-computed values.
    ref_op(F_SLL, 5'd31, 32'h0, 32'h1, r, il);            chk("model_sll31", r, 32'h8000_0000);
    ref_op(F_SRAV, 5'd0, 32'hFFFF_FFE4, 32'h8000_0000, r, il); chk("model_srav", r, 32'hF800_0000);
    ref_op(F_SRA, 5'd31, 32'h0, 32'h8000_0000, r, il);    chk("model_sra31", r, 32'hFFFF_FFFF);
    ref_op(F_ADD, 5'd3, 32'h0, 32'h1234, r, il);          chk("model_illegal", 32'(il), 32'd1);

    // Reset state.
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_result", out_result, 32'h0);
    chk("rst_out_dest", 32'(out_dest), 32'd0);
    chk("rst_out_illegal", 32'(out_illegal), 32'd0);
    reset = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // SLL by 31, two edges to output.
    cycle(1'b1, F_SLL, 5'd31, 32'h0, 32'h1, 5'd8, 1'b1, 1'b0, a);
    chk("sll_edge1_valid", 32'(out_valid), 32'd0);
    cycle(1'b0, 6'h0, 5'h0, 32'h0, 32'h0, 5'h0, 1'b1, 1'b0, a);
    chk("sll_valid", 32'(out_valid), 32'd1);
    chk("sll_result", out_result, 32'h8000_0000);
    chk("sll_dest", 32'(out_dest), 32'd8);
    idle(1'b1);

    // Variable shifts use only rs[4:0].
    cycle(1'b1, F_SRAV, 5'd0, 32'hFFFF_FFE4, 32'h8000_0000, 5'd3, 1'b1, 1'b0, a);
    idle(1'b1);
    chk("srav_result", out_result, 32'hF800_0000);
    cycle(1'b1, F_SRLV, 5'd0, 32'hFFFF_FFE4, 32'h8000_0000, 5'd3, 1'b1, 1'b0, a);
    idle(1'b1);
    chk("srlv_result", out_result, 32'h0800_0000);
    idle(1'b1);

    // Back-to-back SRA/SRL/SLL, no bubbles.
    cycle(1'b1, F_SRA, 5'd4, 32'h0, 32'h8000_00F0, 5'd1, 1'b1, 1'b0, a);
    cycle(1'b1, F_SRL, 5'd4, 32'h0, 32'h8000_00F0, 5'd2, 1'b1, 1'b0, a);
    chk("b2b_sra", out_result, 32'hF800_000F);
    cycle(1'b1, F_SLL, 5'd4, 32'h0, 32'h8000_00F0, 5'd3, 1'b1, 1'b0, a);
    chk("b2b_srl", out_result, 32'h0800_000F);
    idle(1'b1);
    chk("b2b_sll", out_result, 32'h0000_0F00);
    chk("b2b_sll_valid", 32'(out_valid), 32'd1);
    idle(1'b1);
    chk("b2b_drained", 32'(out_valid), 32'd0);

    // Stall: three ops with out_ready low, only two fit.
    cycle(1'b1, F_SLL, 5'd1, 32'h0, 32'h11, 5'd4, 1'b0, 1'b0, a);
    cycle(1'b1, F_SRL, 5'd2, 32'h0, 32'h22, 5'd5, 1'b0, 1'b0, a);
    cycle(1'b1, F_SRA, 5'd3, 32'h0, 32'hF000_0033, 5'd6, 1'b0, 1'b0, a);
    chk("stall_in_ready", 32'(last_in_ready), 32'd0);
    chk("stall_hold_result", out_result, 32'h22);
    guard = 0;
    a = 1'b0;
    while (!a && guard < 20) begin
      cycle(1'b1, F_SRA, 5'd3, 32'h0, 32'hF000_0033, 5'd6, 1'b1, 1'b0, a);
      guard++;
    end
    if (!a) begin
      fails++;
      $display("FAIL stall_accept: op never accepted after %0d cycles", guard);
    end
    repeat (4) idle(1'b1);

    // Illegal funct.
    cycle(1'b1, F_ADD, 5'd2, 32'h5, 32'hFFFF_FFFF, 5'd9, 1'b1, 1'b0, a);
    idle(1'b1);
    chk("illegal_flag", 32'(out_illegal), 32'd1);
    chk("illegal_result", out_result, 32'h0);
    idle(1'b1);

    // Flush with two ops in flight plus one handshaking in the flush cycle.
    cycle(1'b1, F_SLL, 5'd1, 32'h0, 32'h1, 5'd10, 1'b0, 1'b0, a);
    cycle(1'b1, F_SLL, 5'd2, 32'h0, 32'h1, 5'd11, 1'b0, 1'b0, a);
    cycle(1'b1, F_SLL, 5'd3, 32'h0, 32'h1, 5'd12, 1'b0, 1'b1, a);
    chk("flush_valid", 32'(out_valid), 32'd0);
    repeat (3) idle(1'b1);
    chk("flush_never_delivered", 32'(out_valid), 32'd0);

    // Reset while a result is stalled at the output.
    cycle(1'b1, F_SRL, 5'd1, 32'h0, 32'h80, 5'd7, 1'b0, 1'b0, a);
    idle(1'b0);
    chk("prereset_valid", 32'(out_valid), 32'd1);
    @(negedge clock);
    out_ready = 1'b0;
    reset = 1'b1;
    #1;
    chk("async_reset_valid", 32'(out_valid), 32'd0);
    chk("async_reset_result", out_result, 32'h0);
    q.delete();
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("post_reset_in_ready", 32'(in_ready), 32'd1);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      logic [5:0] f;
      logic [4:0] sh;
      logic [31:0] rt;
      int k;
      k = $urandom_range(0, 7);
      f = (k < 6) ? legal[k] : 6'($urandom);
      case ($urandom_range(0, 3))
        0: sh = 5'd0;
        1: sh = 5'd31;
        default: sh = 5'($urandom);
      endcase
      rt = $urandom;
      if ($urandom_range(0, 3) == 0) rt = {1'b1, 31'($urandom)};
      cycle($urandom_range(0, 3) != 0, f, sh, $urandom, rt, 5'($urandom),
            $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0, a);
    end
    repeat (4) idle(1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
